data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in storage; power of two.
REQ-002 Parameter WAIT_CYCLES, default 2: added latency cycles between accept and response; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-005 mem_read  input  1  load request.
REQ-006 mem_write  input  1  store request.
REQ-007 mem  input  3  access code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 addr  input  32  byte address.
REQ-009 write_data  input  32  store data, right-aligned.
REQ-010 req_ready  output  1  responder can accept a request this cycle.
REQ-011 resp_valid  output  1  one-cycle pulse; read_data and err are valid.
REQ-012 read_data  output  32  load result, extended to 32 bits.
REQ-013 err  output  1  access rejected; qualified by resp_valid.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted when (mem_read | mem_write) & req_ready; mem, addr, write_data and the request type SHALL be registered on acceptance, and inputs SHALL be ignored outside IDLE.
REQ-016 On acceptance, the FSM SHALL go IDLE->WAIT and load a counter with WAIT_CYCLES-1; WAIT->RESP when the counter reaches 0; if WAIT_CYCLES=0, it SHALL go IDLE->RESP.
REQ-017 RESP SHALL last one cycle with resp_valid=1 and SHALL then return to IDLE; accept-to-resp_valid latency SHALL be WAIT_CYCLES+1 cycles.
REQ-018 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; any nonzero bit above that range SHALL make the access out of range.
REQ-019 A store SHALL write only the byte lanes selected by mem and addr[1:0]: SB writes 1 lane, SH writes 2 lanes, SW writes 4 lanes; the other lanes SHALL be unchanged.
REQ-020 Load results SHALL be lane-shifted to bit 0; LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL return the full word.
REQ-021 A store SHALL commit to the array on the clock edge that enters RESP.
REQ-022 Load data SHALL be sampled from the array on that same edge.
REQ-023 err=1 SHALL be returned for any of: mem_read and mem_write both 1, invalid mem code (011, 110, 111), out-of-range address, or a store using 100 or 101.
REQ-024 On err, no array write SHALL occur and read_data SHALL be 0.
REQ-025 Outside RESP, read_data and err SHALL hold 0.

Reset
REQ-026 When reset=0 at a clock edge: FSM->IDLE, counter->0, req_ready=1, resp_valid=0, read_data=0, err=0.
REQ-027 Reset asserted in WAIT or RESP SHALL drop the pending request; an uncommitted store SHALL be discarded.
REQ-028 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-029 With MISALIGN_TRAP_EN defined, an LH/LHU/SH access with addr[0]=1, or an LW/SW access with addr[1:0]!=0, SHALL respond with err=1 and no write.
REQ-030 Without MISALIGN_TRAP_EN, the offending low address bits SHALL be treated as 0 (forced alignment) and no err SHALL be raised for misalignment.

Structure
REQ-031 The shared package SHALL hold: the access-code localparams (LB, LH, LW, LBU, LHU), the FSM state enum typedef, and a lane-mask function.
REQ-032 The byte-enabled storage array SHALL be one sub-module, dmem_bank (clk, we[3:0], index, wdata, rdata); the FSM, lane logic and extension logic SHALL stay in the top.

Verification
REQ-033 Latency: WAIT_CYCLES=2; SW 0xDEADBEEF to 0x10, then LW 0x10 -> req_ready low for 3 cycles; resp_valid 3 cycles after each accept; read_data=0xDEADBEEF, err=0.
REQ-034 Extension: after REQ-033, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-035 Lanes: SB 0x55 to 0x11 over 0xDEADBEEF -> LW 0x10 returns 0xDEAD55EF.
REQ-036 Errors: mem_read=mem_write=1; mem=011; addr=0x00100000 with DEPTH_WORDS=1024 -> each gives err=1, read_data=0, memory unchanged.
REQ-037 Misalignment: LW 0x12 -> with MISALIGN_TRAP_EN, err=1; without it, returns word 0x10.
REQ-038 Reset: reset=0 during WAIT of SW 0x1234 to 0x20 -> IDLE next cycle, no resp_valid; LW 0x20 returns the prior value.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for data_mem_responder: access codes, FSM states and lane helpers.
package data_mem_responder_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

   // Byte offset after forced alignment of the low address bits to the access size.
   function automatic logic [1:0] lane_offset(input logic [2:0] code, input logic [1:0] low);
      logic [1:0] off;
      case (code)
         LB, LBU: off = low;
         LH, LHU: off = {low[1], 1'b0};
         default: off = 2'b00;
      endcase
      return off;
   endfunction

   // Byte lanes touched by an access of the given code at the given low address bits.
   function automatic logic [3:0] lane_mask(input logic [2:0] code, input logic [1:0] low);
      logic [3:0] mask;
      logic [1:0] off;
      off = lane_offset(code, low);
      case (code)
         LB, LBU: mask = 4'b0001 << off;
         LH, LHU: mask = 4'b0011 << off;
         LW:      mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/data_mem_responder_bank.sv
// Byte-enabled word storage with asynchronous read; contents are never cleared.
module dmem_bank #(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic [3:0]       we,
   input  logic [IDX_W-1:0] index,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem_r [DEPTH_WORDS];

   // Per-lane write of the selected word.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem_r[index][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   assign rdata = mem_r[index];

endmodule

// File: rtl/data_mem_responder.sv
// Single-request load/store responder with configurable wait latency.
// Define MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of forcing alignment.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  mem,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] read_data,
   output logic        err
);

   localparam int         IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t      state_r, state_next_s;
   logic [3:0]  cnt_r, cnt_next_s;
   logic        req_rd_r, req_wr_r;
   logic [2:0]  mem_r;
   logic [31:0] addr_r, wdata_r;
   logic [31:0] read_data_r;
   logic        err_r;

   logic        accept_s, enter_resp_s;
   logic        cur_rd_s, cur_wr_s;
   logic [2:0]  cur_mem_s;
   logic [31:0] cur_addr_s, cur_wdata_s;
   logic        bad_code_s, oor_s, misalign_s, err_s, store_ok_s, load_ok_s;
   logic [1:0]  off_s;
   logic [3:0]  mask_s, we_s;
   logic [31:0] wdata_lane_s, rdata_s, shifted_s, load_s;

   assign accept_s = (mem_read | mem_write) & (state_r == IDLE);

   // With zero wait the response edge follows acceptance directly, so use live inputs in IDLE.
   always_comb begin
      if (state_r == IDLE) begin
         cur_rd_s    = mem_read;
         cur_wr_s    = mem_write;
         cur_mem_s   = mem;
         cur_addr_s  = addr;
         cur_wdata_s = write_data;
      end else begin
         cur_rd_s    = req_rd_r;
         cur_wr_s    = req_wr_r;
         cur_mem_s   = mem_r;
         cur_addr_s  = addr_r;
         cur_wdata_s = wdata_r;
      end
   end

   // Request capture on acceptance.
   always_ff @(posedge clk) begin
      if (!reset) begin
         req_rd_r <= 1'b0;
         req_wr_r <= 1'b0;
         mem_r    <= 3'b000;
         addr_r   <= 32'd0;
         wdata_r  <= 32'd0;
      end else if (accept_s) begin
         req_rd_r <= mem_read;
         req_wr_r <= mem_write;
         mem_r    <= mem;
         addr_r   <= addr;
         wdata_r  <= write_data;
      end else begin
         req_rd_r <= req_rd_r;
         req_wr_r <= req_wr_r;
         mem_r    <= mem_r;
         addr_r   <= addr_r;
         wdata_r  <= wdata_r;
      end
   end

   // FSM state and wait counter registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (WAIT_CYCLES == 0) begin
                  state_next_s = RESP;
               end else begin
                  state_next_s = WAIT;
                  cnt_next_s   = WAIT_LOAD;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == 4'd0) begin
               state_next_s = RESP;
            end else begin
               cnt_next_s = cnt_r - 4'd1;
            end
         end
         RESP:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   assign enter_resp_s = (state_next_s == RESP) && (state_r != RESP);

   // Access checks on the request being answered.
   always_comb begin
      case (cur_mem_s)
         LB, LH, LW, LBU, LHU: bad_code_s = 1'b0;
         default:             bad_code_s = 1'b1;
      endcase
      oor_s = (cur_addr_s >> (IDX_W + 2)) != 32'd0;
`ifdef MISALIGN_TRAP_EN
      case (cur_mem_s)
         LH, LHU: misalign_s = cur_addr_s[0];
         LW:      misalign_s = cur_addr_s[1:0] != 2'b00;
         default: misalign_s = 1'b0;
      endcase
`else
      misalign_s = 1'b0;
`endif
      err_s = (cur_rd_s & cur_wr_s) | bad_code_s | oor_s | misalign_s |
              (cur_wr_s & ((cur_mem_s == LBU) | (cur_mem_s == LHU)));
      store_ok_s = cur_wr_s & ~cur_rd_s & ~err_s;
      load_ok_s  = cur_rd_s & ~cur_wr_s & ~err_s;
   end

   assign off_s  = lane_offset(cur_mem_s, cur_addr_s[1:0]);
   assign mask_s = lane_mask(cur_mem_s, cur_addr_s[1:0]);

   // Replicate store data so each selected lane sees its own byte/halfword.
   always_comb begin
      case (cur_mem_s)
         LB:      wdata_lane_s = {4{cur_wdata_s[7:0]}};
         LH:      wdata_lane_s = {2{cur_wdata_s[15:0]}};
         default: wdata_lane_s = cur_wdata_s;
      endcase
   end

   assign we_s = (enter_resp_s && store_ok_s && reset) ? mask_s : 4'b0000;

   dmem_bank #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .IDX_W      (IDX_W)
   ) u_bank (
      .clk  (clk),
      .we   (we_s),
      .index(cur_addr_s[IDX_W+1:2]),
      .wdata(wdata_lane_s),
      .rdata(rdata_s)
   );

   assign shifted_s = rdata_s >> {off_s, 3'b000};

   // Load extension from the lane-shifted word.
   always_comb begin
      case (cur_mem_s)
         LB:      load_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
         LH:      load_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
         LBU:     load_s = {24'd0, shifted_s[7:0]};
         LHU:     load_s = {16'd0, shifted_s[15:0]};
         LW:      load_s = rdata_s;
         default: load_s = 32'd0;
      endcase
   end

   // Response registers: loaded on the edge entering RESP, zero otherwise.
   always_ff @(posedge clk) begin
      if (!reset) begin
         read_data_r <= 32'd0;
         err_r       <= 1'b0;
      end else if (enter_resp_s) begin
         read_data_r <= load_ok_s ? load_s : 32'd0;
         err_r       <= err_s;
      end else begin
         read_data_r <= 32'd0;
         err_r       <= 1'b0;
      end
   end

   assign req_ready  = (state_r == IDLE);
   assign resp_valid = (state_r == RESP);
   assign read_data  = read_data_r;
   assign err        = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH_WORDS=1024, WAIT_CYCLES=2).
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write;
   logic [2:0]  mem;
   logic [31:0] addr, write_data;
   logic        req_ready, resp_valid, err;
   logic [31:0] read_data;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   data_mem_responder #(
      .DEPTH_WORDS(1024),
      .WAIT_CYCLES(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem       (mem),
      .addr      (addr),
      .write_data(write_data),
      .req_ready (req_ready),
      .resp_valid(resp_valid),
      .read_data (read_data),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Issue one request from IDLE (called just after a rising edge) and collect its response.
   task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] code,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rdata, output logic e);
      int  lat;
      int  busy;
      mem_read = rd; mem_write = wr; mem = code; addr = a; write_data = wd;
      @(negedge clk);
      check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; mem = 3'b000; addr = 32'd0; write_data = 32'd0;
      lat = 0; busy = 0; rdata = 32'd0; e = 1'b0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (!req_ready) busy++;
         if (resp_valid) begin
            rdata = read_data;
            e = err;
            break;
         end
      end
      check({tag, " latency"}, lat, 32'd3);
      check({tag, " busy"}, busy, 32'd3);
      @(posedge clk); #1;
   endtask

   logic [31:0] rd_v;
   logic        e_v;
   logic        saw_resp;

   initial begin
      reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem = 3'b000;
      addr = 32'd0; write_data = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst ready", {31'd0, req_ready}, 32'd1);
      check("rst valid", {31'd0, resp_valid}, 32'd0);
      check("rst data", read_data, 32'd0);
      check("rst err", {31'd0, err}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      access("sw10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd_v, e_v);
      check("sw10 err", {31'd0, e_v}, 32'd0);
      check("idle data", read_data, 32'd0);
      access("lw10", 1'b1, 1'b0, 3'b010, 32'h10, 32'd0, rd_v, e_v);
      check("lw10 data", rd_v, 32'hDEADBEEF);
      check("lw10 err", {31'd0, e_v}, 32'd0);

      access("lb13", 1'b1, 1'b0, 3'b000, 32'h13, 32'd0, rd_v, e_v);
      check("lb13 data", rd_v, 32'hFFFFFFDE);
      access("lbu13", 1'b1, 1'b0, 3'b100, 32'h13, 32'd0, rd_v, e_v);
      check("lbu13 data", rd_v, 32'h000000DE);
      access("lh12", 1'b1, 1'b0, 3'b001, 32'h12, 32'd0, rd_v, e_v);
      check("lh12 data", rd_v, 32'hFFFFDEAD);
      access("lhu10", 1'b1, 1'b0, 3'b101, 32'h10, 32'd0, rd_v, e_v);
      check("lhu10 data", rd_v, 32'h0000BEEF);

      access("sb11", 1'b0, 1'b1, 3'b000, 32'h11, 32'h00000055, rd_v, e_v);
      access("lw10b", 1'b1, 1'b0, 3'b010, 32'h10, 32'd0, rd_v, e_v);
      check("sb lanes", rd_v, 32'hDEAD55EF);
      access("sh12", 1'b0, 1'b1, 3'b001, 32'h12, 32'hFFFF1234, rd_v, e_v);
      access("lw10c", 1'b1, 1'b0, 3'b010, 32'h10, 32'd0, rd_v, e_v);
      check("sh lanes", rd_v, 32'h123455EF);

      access("sw00", 1'b0, 1'b1, 3'b010, 32'h0, 32'h11223344, rd_v, e_v);
      access("both", 1'b1, 1'b1, 3'b010, 32'h10, 32'h0, rd_v, e_v);
      check("both err", {31'd0, e_v}, 32'd1);
      check("both data", rd_v, 32'd0);
      access("code3", 1'b1, 1'b0, 3'b011, 32'h10, 32'd0, rd_v, e_v);
      check("code3 err", {31'd0, e_v}, 32'd1);
      check("code3 data", rd_v, 32'd0);
      access("oor", 1'b0, 1'b1, 3'b010, 32'h00100000, 32'hFFFFFFFF, rd_v, e_v);
      check("oor err", {31'd0, e_v}, 32'd1);
      access("oorld", 1'b1, 1'b0, 3'b010, 32'h00100010, 32'd0, rd_v, e_v);
      check("oor ld err", {31'd0, e_v}, 32'd1);
      check("oor ld data", rd_v, 32'd0);
      access("sbu", 1'b0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, rd_v, e_v);
      check("sbu err", {31'd0, e_v}, 32'd1);
      access("lw00", 1'b1, 1'b0, 3'b010, 32'h0, 32'd0, rd_v, e_v);
      check("oor no write", rd_v, 32'h11223344);
      access("lw10d", 1'b1, 1'b0, 3'b010, 32'h10, 32'd0, rd_v, e_v);
      check("err no write", rd_v, 32'h123455EF);

      access("lw12", 1'b1, 1'b0, 3'b010, 32'h12, 32'd0, rd_v, e_v);
`ifdef MISALIGN_TRAP_EN
      check("misalign err", {31'd0, e_v}, 32'd1);
      check("misalign data", rd_v, 32'd0);
`else
      check("misalign err", {31'd0, e_v}, 32'd0);
      check("misalign data", rd_v, 32'h123455EF);
`endif

      access("sw20", 1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, rd_v, e_v);
      mem_read = 1'b0; mem_write = 1'b1; mem = 3'b010; addr = 32'h20; write_data = 32'h00001234;
      @(posedge clk); #1;
      mem_write = 1'b0; addr = 32'd0; write_data = 32'd0;
      @(negedge clk);
      check("wait busy", {31'd0, req_ready}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("abort ready", {31'd0, req_ready}, 32'd1);
      saw_resp = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (resp_valid) saw_resp = 1'b1;
      end
      check("abort no resp", {31'd0, saw_resp}, 32'd0);
      @(posedge clk); #1;
      access("lw20", 1'b1, 1'b0, 3'b010, 32'h20, 32'd0, rd_v, e_v);
      check("abort no store", rd_v, 32'hCAFEF00D);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
